// File: rtl/register.sv
// register: WIDTH-bit edge-triggered storage word.
// Three update paths in priority order: sync clear, alternate load, write-enabled load.
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             aload,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_enable,
    output logic [WIDTH-1:0] data_out
);
    always_ff @(posedge clk)
        data_out <= areset ? RESET_VALUE : aload ? adata : write_enable ? data_in : data_out;
endmodule

// File: tb/tb_register.sv
// tb_register: directed vectors feed an expected-value queue; a monitor checks after each rising edge.
module tb_register;
    logic        clk = 1'b0;
    logic        areset = 1'b0, aload = 1'b0, write_enable = 1'b0;
    logic [31:0] adata = '0, data_in = '0, data_out;
    int          errors = 0, checks = 0;
    bit          done = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;
    exp_t sb[$];

    register #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clk(clk), .areset(areset), .aload(aload), .adata(adata),
        .data_in(data_in), .write_enable(write_enable), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: the word loaded by an edge is visible 1 ns after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, data_out, e.value);
        end
    end

    // Drive controls between edges, then queue the value expected after the next edge.
    task automatic step(input string name, input logic ar, input logic al, input logic [31:0] ad,
                        input logic we, input logic [31:0] di, input logic [31:0] want);
        exp_t e;
        areset = ar; aload = al; adata = ad; write_enable = we; data_in = di;
        e.name = name; e.value = want;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        step("write1",        0, 0, 32'h0,        1, 32'hDAAB4620, 32'hDAAB4620);
        step("write2",        0, 0, 32'h0,        1, 32'h12345678, 32'h12345678);
        step("hold",          0, 0, 32'h0,        0, 32'h87654321, 32'h12345678);
        areset = 1'b1;
        #1 check("reset_pre_edge", data_out, 32'h12345678);
        step("reset",         1, 0, 32'h0,        0, 32'h87654321, 32'h00000000);
        step("aload1",        0, 1, 32'h246B780F, 0, 32'h0,        32'h246B780F);
        step("aload2",        0, 1, 32'h246B780F, 0, 32'h11111111, 32'h246B780F);
        step("aload3",        0, 1, 32'h246B780F, 0, 32'h22222222, 32'h246B780F);
        step("prio_all",      1, 1, 32'hA5A5A5A5, 1, 32'h5A5A5A5A, 32'h00000000);
        step("prio_al_we",    0, 1, 32'hA5A5A5A5, 1, 32'h5A5A5A5A, 32'hA5A5A5A5);
        step("prio_ar_al",    1, 1, 32'h11111111, 0, 32'h0,        32'h00000000);
        step("write3",        0, 0, 32'h0,        1, 32'h77777777, 32'h77777777);
        step("reset_drops_we",1, 0, 32'h0,        1, 32'h88888888, 32'h00000000);
        step("post_reset_we", 0, 0, 32'h0,        1, 32'hC0FFEE00, 32'hC0FFEE00);
        step("unsel_adata",   0, 0, 32'hDEADBEEF, 0, 32'h13579BDF, 32'hC0FFEE00);
        // Glitch write_enable strictly between edges.
        @(posedge clk);
        #2 data_in = 32'hFFFFFFFF; write_enable = 1'b1;
        #1 check("glitch_mid", data_out, 32'hC0FFEE00);
        #1 write_enable = 1'b0;
        @(negedge clk);
        step("glitch_edge",   0, 0, 32'h0,        0, 32'hFFFFFFFF, 32'hC0FFEE00);
        step("write_max",     0, 0, 32'h0,        1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: time=%0t limit=5000", $time);
        $fatal(1, "timeout");
    end
endmodule
